// File: rtl/load_receive_unit.sv
// Load receive unit: buffers memory responses in a small FIFO and presents the
// head entry as an aligned, sign/zero-extended load result with its tag.
// Optional macro LOAD_RECEIVE_MISALIGN_DETECT_EN: flag misaligned accesses
// (misaligned=1, load_data=0) instead of masking the offset down to alignment.
module load_receive_unit #(
  parameter int unsigned CORE         = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    memory_valid,
  input  logic [DATA_WIDTH-1:0]   memory_data_in,
  input  logic [ADDRESS_BITS-1:0] memory_address,
  input  logic [2:0]              load_type,
  input  logic [4:0]              load_rd,
  output logic                    memory_ready,
  output logic                    load_valid,
  input  logic                    writeback_ready,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic [4:0]              load_rd_out,
  output logic                    misaligned,
  input  logic                    scan
);

  localparam int unsigned OffW = $clog2(DATA_WIDTH / 8);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [OffW-1:0]       off_mem  [FIFO_DEPTH];
  logic [2:0]            type_mem [FIFO_DEPTH];
  logic [4:0]            rd_mem   [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            full, empty, push, pop;

  // Only the lane offset bits of the address are stored.
  logic unused_addr;
  assign unused_addr = ^memory_address[ADDRESS_BITS-1:OffW];

  assign full         = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign empty        = (count_q == '0);
  assign memory_ready = !full;
  assign load_valid   = !empty;
  assign push         = memory_valid && !full;
  assign pop          = !empty && writeback_ready;

  // Occupancy next state: push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer/count state; reset dominates any push or pop in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry storage at the tail; pointers alone define validity.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      data_mem[wr_ptr_q] <= memory_data_in;
      off_mem[wr_ptr_q]  <= memory_address[OffW-1:0];
      type_mem[wr_ptr_q] <= load_type;
      rd_mem[wr_ptr_q]   <= load_rd;
    end
  end

`ifndef SYNTHESIS
  // Per-accept trace when scan is enabled.
  always_ff @(posedge clock) begin
    if (!reset && push && scan) begin
      $display("[LRU core %0d] rd=%0d addr=%h data=%h", CORE, load_rd, memory_address,
               memory_data_in);
    end
  end
`endif

  logic [DATA_WIDTH-1:0] head_data;
  logic [OffW-1:0]       head_off;
  logic [2:0]            head_type;
  logic [4:0]            head_rd;

  assign head_data = data_mem[rd_ptr_q];
  assign head_off  = off_mem[rd_ptr_q];
  assign head_type = type_mem[rd_ptr_q];
  assign head_rd   = rd_mem[rd_ptr_q];

  logic [1:0] size_log;  // log2 of access size in bytes
  logic       is_signed;

  // Decode funct3 into access size and extension; unknown codes act as a full word.
  always_comb begin
    size_log  = 2'd3;
    is_signed = 1'b0;
    case (head_type)
      3'b000:  begin size_log = 2'd0; is_signed = 1'b1; end
      3'b001:  begin size_log = 2'd1; is_signed = 1'b1; end
      3'b010:  begin size_log = 2'd2; is_signed = 1'b1; end
      3'b011:  begin size_log = 2'd3; is_signed = 1'b0; end
      3'b100:  begin size_log = 2'd0; is_signed = 1'b0; end
      3'b101:  begin size_log = 2'd1; is_signed = 1'b0; end
      3'b110:  begin size_log = 2'd2; is_signed = 1'b0; end
      default: begin size_log = 2'd3; is_signed = 1'b0; end
    endcase
    // Accesses as wide as the bus return the word untouched.
    if (32'(size_log) > OffW) size_log = 2'(OffW);
  end

  logic [OffW-1:0]       size_mask, off_aligned;
  logic [DATA_WIDTH-1:0] shifted, ext_data;
  logic signed [7:0]     lane_b;
  logic signed [15:0]    lane_h;
  logic signed [31:0]    lane_w;
  logic                  head_mis;

  assign size_mask   = OffW'((32'd1 << size_log) - 32'd1);
  assign off_aligned = head_off & ~size_mask;
  assign shifted     = head_data >> {off_aligned, 3'b000};
  assign lane_b      = shifted[7:0];
  assign lane_h      = shifted[15:0];
  assign lane_w      = shifted[31:0];

`ifdef LOAD_RECEIVE_MISALIGN_DETECT_EN
  assign head_mis = |(head_off & size_mask);
`else
  assign head_mis = 1'b0;
`endif

  // Lane extraction with sign or zero extension to the bus width.
  always_comb begin
    ext_data = shifted;
    if (32'(size_log) != OffW) begin
      case (size_log)
        2'd0: begin
          if (is_signed) ext_data = DATA_WIDTH'(lane_b);
          else           ext_data = DATA_WIDTH'(shifted[7:0]);
        end
        2'd1: begin
          if (is_signed) ext_data = DATA_WIDTH'(lane_h);
          else           ext_data = DATA_WIDTH'(shifted[15:0]);
        end
        2'd2: begin
          if (is_signed) ext_data = DATA_WIDTH'(lane_w);
          else           ext_data = DATA_WIDTH'(shifted[31:0]);
        end
        default: ext_data = shifted;
      endcase
    end
  end

  // Head outputs, forced to zero while the buffer is empty.
  always_comb begin
    load_data   = '0;
    load_rd_out = '0;
    misaligned  = 1'b0;
    if (!empty) begin
      load_rd_out = head_rd;
      misaligned  = head_mis;
      load_data   = head_mis ? '0 : ext_data;
    end
  end

endmodule

// File: tb/tb_load_receive_unit.sv
module tb_load_receive_unit;

  localparam int DW = 32;
  localparam int AB = 20;
  localparam int FD = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          memory_valid;
  logic [DW-1:0] memory_data_in;
  logic [AB-1:0] memory_address;
  logic [2:0]    load_type;
  logic [4:0]    load_rd;
  logic          memory_ready;
  logic          load_valid;
  logic          writeback_ready;
  logic [DW-1:0] load_data;
  logic [4:0]    load_rd_out;
  logic          misaligned;
  logic          scan;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  load_receive_unit #(
    .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock), .reset(reset), .memory_valid(memory_valid),
    .memory_data_in(memory_data_in), .memory_address(memory_address),
    .load_type(load_type), .load_rd(load_rd), .memory_ready(memory_ready),
    .load_valid(load_valid), .writeback_ready(writeback_ready), .load_data(load_data),
    .load_rd_out(load_rd_out), .misaligned(misaligned), .scan(scan)
  );

  typedef struct {
    logic [31:0] data;
    logic [19:0] addr;
    logic [2:0]  ltype;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] d, input logic [19:0] a, input logic [2:0] t,
                          input logic [4:0] rd);
    memory_valid   = 1'b1;
    memory_data_in = d;
    memory_address = a;
    load_type      = t;
    load_rd        = rd;
    tick();
    memory_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h80F0_1234, 20'h3, 3'b000, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{32'h80F0_1234, 20'h3, 3'b100, 32'h0000_0080, 1'b0};
    vecs[2]  = '{32'h8001_7FFF, 20'h2, 3'b001, 32'hFFFF_8001, 1'b0};
    vecs[3]  = '{32'h8001_7FFF, 20'h0, 3'b001, 32'h0000_7FFF, 1'b0};
    vecs[4]  = '{32'h8001_7FFF, 20'h2, 3'b101, 32'h0000_8001, 1'b0};
    vecs[5]  = '{32'h80F0_1234, 20'h1, 3'b000, 32'h0000_0012, 1'b0};
    vecs[6]  = '{32'h80F0_1234, 20'h2, 3'b000, 32'hFFFF_FFF0, 1'b0};
    vecs[7]  = '{32'hDEAD_BEEF, 20'h0, 3'b010, 32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{32'hDEAD_BEEF, 20'h0, 3'b110, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{32'hCAFE_F00D, 20'h0, 3'b011, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{32'h1357_9BDF, 20'hFFF00, 3'b111, 32'h1357_9BDF, 1'b0};
`ifdef LOAD_RECEIVE_MISALIGN_DETECT_EN
    vecs[11] = '{32'h1122_3344, 20'h2, 3'b010, 32'h0000_0000, 1'b1};
    vecs[12] = '{32'h8001_7FFF, 20'h1, 3'b001, 32'h0000_0000, 1'b1};
    vecs[13] = '{32'h8001_7FFF, 20'h3, 3'b101, 32'h0000_0000, 1'b1};
`else
    vecs[11] = '{32'h1122_3344, 20'h2, 3'b010, 32'h1122_3344, 1'b0};
    vecs[12] = '{32'h8001_7FFF, 20'h1, 3'b001, 32'h0000_7FFF, 1'b0};
    vecs[13] = '{32'h8001_7FFF, 20'h3, 3'b101, 32'h0000_8001, 1'b0};
`endif

    reset = 1'b1; memory_valid = 1'b0; memory_data_in = '0; memory_address = '0;
    load_type = '0; load_rd = '0; writeback_ready = 1'b0; scan = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_ready", 64'(memory_ready), 64'd1);
    check("reset_valid", 64'(load_valid), 64'd0);
    check("reset_data", 64'(load_data), 64'd0);
    check("reset_rd", 64'(load_rd_out), 64'd0);
    check("reset_mis", 64'(misaligned), 64'd0);

    // Table of single-entry extraction vectors.
    for (int i = 0; i < 14; i++) begin
      memory_valid   = 1'b1;
      memory_data_in = vecs[i].data;
      memory_address = vecs[i].addr;
      load_type      = vecs[i].ltype;
      load_rd        = 5'(i + 1);
      #1;
      check($sformatf("no_bypass[%0d]", i), 64'(load_valid), 64'd0);
      tick();
      memory_valid = 1'b0;
      check($sformatf("vec_valid[%0d]", i), 64'(load_valid), 64'd1);
      check($sformatf("vec_data[%0d]", i), 64'(load_data), 64'(vecs[i].exp_data));
      check($sformatf("vec_mis[%0d]", i), 64'(misaligned), 64'(vecs[i].exp_mis));
      check($sformatf("vec_rd[%0d]", i), 64'(load_rd_out), 64'(i + 1));
      writeback_ready = 1'b1;
      tick();
      writeback_ready = 1'b0;
      check($sformatf("vec_drain[%0d]", i), 64'(load_valid), 64'd0);
    end

    // Five back-to-back responses into a depth-4 buffer, then drain in order.
    for (int k = 0; k < 5; k++) begin
      memory_valid = 1'b1; memory_data_in = 32'(100 + k); memory_address = '0;
      load_type = 3'b010; load_rd = 5'(10 + k);
      tick();
      check($sformatf("fill_ready[%0d]", k), 64'(memory_ready), (k < 3) ? 64'd1 : 64'd0);
    end
    memory_valid = 1'b0;
    writeback_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_valid[%0d]", k), 64'(load_valid), 64'd1);
      check($sformatf("drain_rd[%0d]", k), 64'(load_rd_out), 64'(10 + k));
      check($sformatf("drain_data[%0d]", k), 64'(load_data), 64'(100 + k));
      tick();
    end
    check("drain_empty", 64'(load_valid), 64'd0);
    writeback_ready = 1'b0;

    // Full buffer with valid and pop together: pop only, no push.
    for (int k = 0; k < 4; k++) push_one(32'(200 + k), 20'h0, 3'b010, 5'(20 + k));
    check("full_ready", 64'(memory_ready), 64'd0);
    memory_valid = 1'b1; load_rd = 5'd24; memory_data_in = 32'd999;
    writeback_ready = 1'b1;
    tick();
    memory_valid = 1'b0;
    check("fullpop_ready", 64'(memory_ready), 64'd1);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("fullpop_valid[%0d]", k), 64'(load_valid), 64'd1);
      check($sformatf("fullpop_rd[%0d]", k), 64'(load_rd_out), 64'(20 + k));
      tick();
    end
    check("fullpop_empty", 64'(load_valid), 64'd0);
    writeback_ready = 1'b0;

    // Simultaneous push and pop with one entry keeps occupancy at one.
    push_one(32'd5, 20'h0, 3'b010, 5'd5);
    memory_valid = 1'b1; memory_data_in = 32'd6; load_rd = 5'd6;
    writeback_ready = 1'b1;
    tick();
    memory_valid = 1'b0; writeback_ready = 1'b0;
    check("pp_valid", 64'(load_valid), 64'd1);
    check("pp_rd", 64'(load_rd_out), 64'd6);
    check("pp_data", 64'(load_data), 64'd6);
    writeback_ready = 1'b1;
    tick();
    writeback_ready = 1'b0;
    check("pp_empty", 64'(load_valid), 64'd0);

    // Reset with two entries queued and a concurrent push/pop discards everything.
    push_one(32'd7, 20'h0, 3'b010, 5'd7);
    push_one(32'd8, 20'h0, 3'b010, 5'd8);
    reset = 1'b1; memory_valid = 1'b1; memory_data_in = 32'd9; load_rd = 5'd9;
    writeback_ready = 1'b1;
    tick();
    reset = 1'b0; memory_valid = 1'b0; writeback_ready = 1'b0;
    check("rst_valid", 64'(load_valid), 64'd0);
    check("rst_ready", 64'(memory_ready), 64'd1);
    check("rst_data", 64'(load_data), 64'd0);
    check("rst_rd", 64'(load_rd_out), 64'd0);
    push_one(32'h80F0_1234, 20'h3, 3'b000, 5'd3);
    check("post_rst_valid", 64'(load_valid), 64'd1);
    check("post_rst_data", 64'(load_data), 64'hFFFF_FF80);
    check("post_rst_rd", 64'(load_rd_out), 64'd3);
    writeback_ready = 1'b1;
    tick();
    writeback_ready = 1'b0;
    check("post_rst_empty", 64'(load_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
